// File: rtl/twiddle_sequencer_pkg.sv
// Shared types and elaboration helpers for the radix-2 DIF twiddle sequencer.
package twiddle_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP,
        ST_FLUSH,
        ST_DONE
    } seq_state_t;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/twiddle_sequencer_bf_index_calc.sv
// Combinational butterfly index map for one radix-2 DIF pass: (stage, j) -> twiddle k, top, bot.
module bf_index_calc
    import twiddle_sequencer_pkg::*;
#(
    parameter int FFT_SIZE = 4096
) (
    input  logic [$clog2(FFT_SIZE)-1:0]   stage,
    input  logic [$clog2(FFT_SIZE/2)-1:0] index,
    output logic [$clog2(FFT_SIZE/2)-1:0] k,
    output logic [$clog2(FFT_SIZE)-1:0]   top,
    output logic [$clog2(FFT_SIZE)-1:0]   bot
);

    localparam int IDX_W     = $clog2(FFT_SIZE);
    localparam int TW_ADDR_W = $clog2(FFT_SIZE/2);

    logic [IDX_W-1:0] j_ext;
    logic [IDX_W-1:0] half;
    logic [IDX_W-1:0] mask;
    logic [IDX_W-1:0] low;

    // half is a power of two, so j mod half and (j/half)*2*half reduce to masking and a shift.
    assign j_ext = {1'b0, index};
    assign half  = IDX_W'(FFT_SIZE/2) >> stage;
    assign mask  = half - IDX_W'(1);
    assign low   = j_ext & mask;

    assign top = ((j_ext & ~mask) << 1) | low;
    assign bot = top + half;
    assign k   = TW_ADDR_W'(low << stage);

endmodule

// File: rtl/twiddle_sequencer.sv
// Issues one radix-2 DIF butterfly per beat over all stages, keeping the 1-cycle twiddle ROM
// read aligned with the beat held in the output register across downstream stalls.
module twiddle_sequencer
    import twiddle_sequencer_pkg::*;
#(
    parameter int FFT_SIZE      = 4096,
    parameter int TWIDDLE_WIDTH = 50,
    parameter int STAGE_GAP     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FFT_SIZE/2)-1:0] twiddle_addr,
    input  logic [TWIDDLE_WIDTH-1:0]      twiddle_in,
    output logic                          bf_valid,
    input  logic                          bf_ready,
    output logic [$clog2(FFT_SIZE)-1:0]   bf_stage,
    output logic [$clog2(FFT_SIZE)-1:0]   bf_top,
    output logic [$clog2(FFT_SIZE)-1:0]   bf_bot,
    output logic [TWIDDLE_WIDTH-1:0]      bf_twiddle
);

    localparam int IDX_W     = $clog2(FFT_SIZE);
    localparam int TW_ADDR_W = $clog2(FFT_SIZE/2);
    localparam int GAP_W     = cnt_width(STAGE_GAP);

    localparam logic [TW_ADDR_W-1:0] J_LAST   = TW_ADDR_W'(FFT_SIZE/2 - 1);
    localparam logic [IDX_W-1:0]     S_LAST   = IDX_W'(IDX_W - 1);
    localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);

    seq_state_t state;
    seq_state_t state_next;

    logic [IDX_W-1:0]     s_cnt;
    logic [TW_ADDR_W-1:0] j_cnt;
    logic [GAP_W-1:0]     gap_cnt;

    logic [TW_ADDR_W-1:0] k_calc;
    logic [IDX_W-1:0]     top_calc;
    logic [IDX_W-1:0]     bot_calc;
    logic [TW_ADDR_W-1:0] bf_k;

    logic adv;
    logic issue;

    assign adv   = !bf_valid || bf_ready;
    assign issue = adv && (state == ST_ISSUE);

    bf_index_calc #(
        .FFT_SIZE (FFT_SIZE)
    ) u_index (
        .stage (s_cnt),
        .index (j_cnt),
        .k     (k_calc),
        .top   (top_calc),
        .bot   (bot_calc)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (issue && (j_cnt == J_LAST)) begin
                    if (s_cnt == S_LAST)    state_next = ST_FLUSH;
                    else if (STAGE_GAP > 0) state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) state_next = ST_ISSUE;
            end
            ST_FLUSH: begin
                if (bf_valid && bf_ready) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_ISSUE, ST_GAP, ST_FLUSH: busy = 1'b1;
            ST_DONE:                    done = 1'b1;
            default: ;
        endcase
    end

    // Stage/butterfly/gap counters advance only with an issued beat or a gap cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_cnt   <= '0;
            j_cnt   <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    s_cnt   <= '0;
                    j_cnt   <= '0;
                    gap_cnt <= '0;
                end
                ST_ISSUE: begin
                    if (issue) begin
                        if (j_cnt == J_LAST) begin
                            j_cnt <= '0;
                            if (s_cnt != S_LAST) s_cnt <= s_cnt + IDX_W'(1);
                        end else begin
                            j_cnt <= j_cnt + TW_ADDR_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + GAP_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Single-entry output register; bf_k remembers the held beat's twiddle address.
    always_ff @(posedge clk) begin
        if (rst) begin
            bf_valid <= 1'b0;
            bf_stage <= '0;
            bf_top   <= '0;
            bf_bot   <= '0;
            bf_k     <= '0;
        end else if (adv) begin
            if (state == ST_ISSUE) begin
                bf_valid <= 1'b1;
                bf_stage <= s_cnt;
                bf_top   <= top_calc;
                bf_bot   <= bot_calc;
                bf_k     <= k_calc;
            end else begin
                bf_valid <= 1'b0;
            end
        end
    end

    // The ROM registers this address, so its output lines up with whatever the output register holds.
    assign twiddle_addr = issue ? k_calc : bf_k;
    assign bf_twiddle   = twiddle_in;

endmodule

// File: tb/tb_twiddle_sequencer.sv
// Randomized self-checking bench: a 16-point DUT (gap 4) under stalls, restarts and abort,
// plus a default 4096-point DUT, both compared against a formula-level butterfly model.
module tb_twiddle_sequencer;

    localparam int SN = 16;
    localparam int BN = 4096;
    localparam int SMALL_BEATS = 32;
    localparam int BIG_BEATS   = 24576;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 16-point instance
    logic        s_rst, s_start, s_busy, s_done, s_valid, s_ready;
    logic [2:0]  s_addr;
    logic [49:0] s_tw_in, s_tw;
    logic [3:0]  s_stage, s_top, s_bot;

    // 4096-point instance
    logic        b_rst, b_start, b_busy, b_done, b_valid, b_ready;
    logic [10:0] b_addr;
    logic [49:0] b_tw_in, b_tw;
    logic [11:0] b_stage, b_top, b_bot;

    logic [61:0] cap [SMALL_BEATS];

    twiddle_sequencer #(
        .FFT_SIZE      (SN),
        .TWIDDLE_WIDTH (50),
        .STAGE_GAP     (4)
    ) u_dut_small (
        .clk          (clk),
        .rst          (s_rst),
        .start        (s_start),
        .busy         (s_busy),
        .done         (s_done),
        .twiddle_addr (s_addr),
        .twiddle_in   (s_tw_in),
        .bf_valid     (s_valid),
        .bf_ready     (s_ready),
        .bf_stage     (s_stage),
        .bf_top       (s_top),
        .bf_bot       (s_bot),
        .bf_twiddle   (s_tw)
    );

    twiddle_sequencer u_dut_big (
        .clk          (clk),
        .rst          (b_rst),
        .start        (b_start),
        .busy         (b_busy),
        .done         (b_done),
        .twiddle_addr (b_addr),
        .twiddle_in   (b_tw_in),
        .bf_valid     (b_valid),
        .bf_ready     (b_ready),
        .bf_stage     (b_stage),
        .bf_top       (b_top),
        .bf_bot       (b_bot),
        .bf_twiddle   (b_tw)
    );

    function automatic logic [49:0] rom_word(input int unsigned a);
        return 50'(a) * 50'd1000003 + 50'd12345;
    endfunction

    // Behavioural twiddle ROMs: one-cycle registered read.
    always @(posedge clk) s_tw_in <= rom_word(32'(s_addr));
    always @(posedge clk) b_tw_in <= rom_word(32'(b_addr));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_beat(input int n, input int s, input int j,
                                     output int k, output int top, output int bot);
        int half;
        half = n >> (s + 1);
        k    = (j % half) << s;
        top  = (j / half) * 2 * half + (j % half);
        bot  = top + half;
    endfunction

    function automatic logic [61:0] small_expected(input int idx);
        int k, top, bot;
        ref_beat(SN, idx / (SN/2), idx % (SN/2), k, top, bot);
        return {4'(idx / (SN/2)), 4'(top), 4'(bot), rom_word(32'(k))};
    endfunction

    function automatic logic [61:0] small_payload();
        return {s_stage, s_top, s_bot, s_tw};
    endfunction

    // One 16-point transform; poke pulses start mid-run and again during done,
    // abort_at > 0 asserts rst right after that many accepted beats.
    task automatic run_small(input int ready_pct, input bit poke, input int abort_at);
        int cyc, beat, dones, zero_run, last_hs, done_cyc;
        bit holding, stop, seen_first, start_next;
        logic [61:0] held;
        cyc = 0; beat = 0; dones = 0; zero_run = 0; last_hs = -100; done_cyc = -1;
        holding = 1'b0; stop = 1'b0; seen_first = 1'b0; start_next = 1'b1; held = '0;
        while (!stop) begin
            @(posedge clk); #1;
            s_start    = start_next;
            start_next = 1'b0;
            s_ready    = ($urandom_range(99) < 32'(ready_pct));
            @(negedge clk);
            if (cyc == 1) check("busy_after_start", s_busy, 1);
            if (s_valid && !seen_first) begin
                seen_first = 1'b1;
                check("first_valid_latency", cyc, 2);
            end
            if (holding) check("stall_hold", {s_valid, small_payload()}, {1'b1, held});
            holding = s_valid && !s_ready;
            held    = small_payload();
            if (s_valid && s_ready) begin
                if (beat < SMALL_BEATS) begin
                    check("beat", small_payload(), small_expected(beat));
                    if (ready_pct == 100 && beat > 0)
                        check("gap_len", zero_run, (beat % (SN/2) == 0) ? 4 : 0);
                    cap[beat] = small_payload();
                end else begin
                    check("extra_beat", beat, SMALL_BEATS - 1);
                end
                beat++;
                last_hs  = cyc;
                zero_run = 0;
            end else if (!s_valid && beat > 0) begin
                zero_run++;
            end
            if (s_done) begin
                dones++;
                done_cyc = cyc;
                check("done_after_last", cyc - last_hs, 1);
                check("done_beats", beat, SMALL_BEATS);
                check("busy_with_done", s_busy, 0);
                if (poke) s_start = 1'b1;
            end else if (done_cyc >= 0) begin
                check("idle_after_done", {s_busy, s_valid, s_done}, 3'b000);
            end
            if (poke && cyc == 15) begin
                check("busy_at_poke", s_busy, 1);
                s_start = 1'b1;
            end
            if (abort_at > 0 && beat == abort_at) begin
                s_rst = 1'b1;
                stop  = 1'b1;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 6) stop = 1'b1;
            if (cyc >= 600) stop = 1'b1;
            cyc++;
        end
        if (abort_at == 0) begin
            check("done_count", dones, 1);
            check("beat_count", beat, SMALL_BEATS);
        end else begin
            check("abort_no_done", dones, 0);
        end
    endtask

    task automatic abort_followup();
        int stray;
        stray = 0;
        @(posedge clk); #1;
        s_rst   = 1'b0;
        s_ready = 1'b1;
        @(negedge clk);
        check("abort_outputs", {s_valid, s_busy, s_done, s_stage, s_top, s_bot, s_addr}, '0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s_valid || s_busy || s_done) stray++;
        end
        check("abort_quiet", stray, 0);
    endtask

    task automatic run_big();
        int cyc, beat, dones, done_cyc, k, top, bot, s, j;
        int max_addr, max_bot;
        cyc = 0; beat = 0; dones = 0; done_cyc = -1; max_addr = 0; max_bot = 0;
        @(posedge clk); #1;
        b_start = 1'b1;
        b_ready = 1'b1;
        while (cyc < 30000 && (done_cyc < 0 || cyc < done_cyc + 4)) begin
            @(posedge clk); #1;
            b_start = 1'b0;
            @(negedge clk);
            if (int'(b_addr) > max_addr) max_addr = int'(b_addr);
            if (b_valid && b_ready) begin
                s = beat / (BN/2);
                j = beat % (BN/2);
                ref_beat(BN, s, j, k, top, bot);
                check("big_beat", {b_stage, b_top, b_bot, b_tw},
                      {12'(s), 12'(top), 12'(bot), rom_word(32'(k))});
                if (int'(b_bot) > max_bot) max_bot = int'(b_bot);
                beat++;
            end
            if (b_done) begin
                dones++;
                done_cyc = cyc;
            end
            cyc++;
        end
        check("big_beats", beat, BIG_BEATS);
        check("big_dones", dones, 1);
        check("big_max_addr", max_addr, BN/2 - 1);
        check("big_max_bot", max_bot, BN - 1);
    endtask

    initial begin
        s_rst = 1'b1; s_start = 1'b0; s_ready = 1'b0;
        b_rst = 1'b1; b_start = 1'b0; b_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_small", {s_valid, s_busy, s_done, s_stage, s_top, s_bot, s_addr}, '0);
        check("reset_big",   {b_valid, b_busy, b_done, b_stage, b_top, b_bot, b_addr}, '0);
        @(posedge clk); #1;
        s_rst = 1'b0;
        b_rst = 1'b0;

        run_small(100, 1'b0, 0);
        check("spot_s0_j3", cap[3],  {4'd0, 4'd3,  4'd11, rom_word(3)});
        check("spot_s1_j5", cap[13], {4'd1, 4'd9,  4'd13, rom_word(2)});
        check("spot_s3_j6", cap[30], {4'd3, 4'd12, 4'd13, rom_word(0)});

        run_small(50, 1'b0, 0);
        run_small(100, 1'b1, 0);
        run_small(100, 1'b0, 10);
        abort_followup();
        run_small(100, 1'b0, 0);
        run_small(50, 1'b1, 0);

        run_big();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
